// File: rtl/sound_sequencer.sv
// Melody sequencer: turns eat/crash game events into timed note sequences
// (frequency + playSound) for the downstream tone oscillator.
module sound_sequencer #(
    parameter int NOTE_CYCLES = 1_000_000,
    parameter int GAP_CYCLES  = 100_000
) (
    input  logic       clk,
    input  logic       nRst,
    input  logic       eat_i,
    input  logic       crash_i,
    input  logic       sound_en,
    output logic [8:0] freq,
    output logic       playSound,
    output logic       busy
);
    localparam int MAXC = (NOTE_CYCLES > GAP_CYCLES) ? NOTE_CYCLES : GAP_CYCLES;
    localparam int CW   = $clog2(MAXC + 1);
    localparam logic [CW-1:0] NOTE_LOAD = CW'(NOTE_CYCLES - 1);
    localparam logic [CW-1:0] GAP_LOAD  = CW'((GAP_CYCLES > 0) ? GAP_CYCLES - 1 : 0);

    typedef enum logic [1:0] {IDLE, PLAY, GAP} state_t;

    state_t        state_q;
    logic          crash_mel_q;
    logic [1:0]    idx_q;
    logic [CW-1:0] cnt_q;
    logic          eat_q, crash_q;
    logic [8:0]    freq_q;
    logic          play_q, busy_q;

    logic       eat_evt, crash_evt, last_note, eat_ok;
    logic [1:0] idx_d;

    function automatic logic [8:0] note_hz(input logic crash, input logic [1:0] idx);
        logic [8:0] hz;
        hz = 9'd0;
        if (crash) begin
            case (idx)
                2'd0:    hz = 9'd392;
                2'd1:    hz = 9'd311;
                2'd2:    hz = 9'd262;
                default: hz = 9'd196;
            endcase
        end else begin
            case (idx)
                2'd0:    hz = 9'd262;
                2'd1:    hz = 9'd330;
                default: hz = 9'd392;
            endcase
        end
        return hz;
    endfunction

    assign eat_evt   = eat_i & ~eat_q;
    assign crash_evt = crash_i & ~crash_q;
    assign last_note = crash_mel_q ? (idx_q == 2'd3) : (idx_q == 2'd2);
    // An eat event may only interrupt silence or another eat melody.
    assign eat_ok    = (state_q == IDLE) || !crash_mel_q;
    assign idx_d     = idx_q + 2'd1;

    always_ff @(posedge clk or negedge nRst) begin
        if (!nRst) begin
            state_q     <= IDLE;
            crash_mel_q <= 1'b0;
            idx_q       <= 2'd0;
            cnt_q       <= '0;
            eat_q       <= 1'b0;
            crash_q     <= 1'b0;
            freq_q      <= 9'd0;
            play_q      <= 1'b0;
            busy_q      <= 1'b0;
        end else begin
            // History always tracks the inputs so muted edges are consumed, not queued.
            eat_q   <= eat_i;
            crash_q <= crash_i;
            if (!sound_en) begin
                state_q <= IDLE;
                idx_q   <= 2'd0;
                cnt_q   <= '0;
                freq_q  <= 9'd0;
                play_q  <= 1'b0;
                busy_q  <= 1'b0;
            end else if (crash_evt || (eat_evt && eat_ok)) begin
                state_q     <= PLAY;
                crash_mel_q <= crash_evt;
                idx_q       <= 2'd0;
                cnt_q       <= NOTE_LOAD;
                freq_q      <= note_hz(crash_evt, 2'd0);
                play_q      <= 1'b1;
                busy_q      <= 1'b1;
            end else begin
                case (state_q)
                    PLAY: begin
                        if (cnt_q != '0) begin
                            cnt_q <= cnt_q - 1'b1;
                        end else if (last_note) begin
                            state_q <= IDLE;
                            idx_q   <= 2'd0;
                            freq_q  <= 9'd0;
                            play_q  <= 1'b0;
                            busy_q  <= 1'b0;
                        end else if (GAP_CYCLES > 0) begin
                            state_q <= GAP;
                            cnt_q   <= GAP_LOAD;
                            freq_q  <= 9'd0;
                            play_q  <= 1'b0;
                        end else begin
                            idx_q  <= idx_d;
                            cnt_q  <= NOTE_LOAD;
                            freq_q <= note_hz(crash_mel_q, idx_d);
                        end
                    end
                    GAP: begin
                        if (cnt_q != '0) begin
                            cnt_q <= cnt_q - 1'b1;
                        end else begin
                            state_q <= PLAY;
                            idx_q   <= idx_d;
                            cnt_q   <= NOTE_LOAD;
                            freq_q  <= note_hz(crash_mel_q, idx_d);
                            play_q  <= 1'b1;
                        end
                    end
                    default: begin
                        state_q <= IDLE;
                        freq_q  <= 9'd0;
                        play_q  <= 1'b0;
                        busy_q  <= 1'b0;
                    end
                endcase
            end
        end
    end

    assign freq      = freq_q;
    assign playSound = play_q;
    assign busy      = busy_q;
endmodule

// File: tb/tb_sound_sequencer.sv
// Directed bench for sound_sequencer: one gapped instance (4/2) and one
// gapless instance (4/0) sharing stimulus.
module tb_sound_sequencer;
    logic       clk = 1'b0;
    logic       nRst = 1'b0;
    logic       eat_i = 1'b0, crash_i = 1'b0, sound_en = 1'b1;
    logic [8:0] freq, freq0;
    logic       playSound, busy, playSound0, busy0;

    int tests = 0;
    int fails = 0;
    int erom[3] = '{262, 330, 392};
    int crom[4] = '{392, 311, 262, 196};

    sound_sequencer #(.NOTE_CYCLES(4), .GAP_CYCLES(2)) dut (
        .clk(clk), .nRst(nRst), .eat_i(eat_i), .crash_i(crash_i), .sound_en(sound_en),
        .freq(freq), .playSound(playSound), .busy(busy)
    );
    sound_sequencer #(.NOTE_CYCLES(4), .GAP_CYCLES(0)) dut_ng (
        .clk(clk), .nRst(nRst), .eat_i(eat_i), .crash_i(crash_i), .sound_en(sound_en),
        .freq(freq0), .playSound(playSound0), .busy(busy0)
    );

    always #5 clk = ~clk;

    // Expected frequency k edges after melody start (k=0 is the trigger edge).
    function automatic int exp_freq(input bit crash, input int k, input int gap);
        int per, n, off, len;
        per = 4 + gap;
        n   = k / per;
        off = k % per;
        len = crash ? 4 : 3;
        if (k < 0 || n >= len || off >= 4) return 0;
        return crash ? crom[n] : erom[n];
    endfunction

    function automatic bit exp_busy(input bit crash, input int k, input int gap);
        int len;
        len = crash ? 4 : 3;
        return (k >= 0) && (k < len * 4 + (len - 1) * gap);
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        #1;
        tests++;
        if (freq !== 9'd0 || playSound !== 1'b0 || busy !== 1'b0)
            $display("FAIL reset_init freq=%0d play=%0b busy=%0b exp 0/0/0", freq, playSound, busy);
        if (freq !== 9'd0 || playSound !== 1'b0 || busy !== 1'b0) fails++;
        // crash held across reset release counts as an edge
        crash_i = 1'b1;
        @(negedge clk);
        nRst = 1'b1;
        for (int k = 0; k <= 24; k++) begin
            tick();
            tests++;
            if (freq !== 9'(exp_freq(1, k, 2)) || busy !== exp_busy(1, k, 2) ||
                playSound !== (exp_freq(1, k, 2) != 0)) begin
                fails++;
                $display("FAIL reset_release_crash k=%0d freq=%0d busy=%0b exp freq=%0d busy=%0b",
                         k, freq, busy, exp_freq(1, k, 2), exp_busy(1, k, 2));
            end
        end
        crash_i = 1'b0;
        tick();
        // reset mid-melody must clear outputs with no clock edge
        eat_i = 1'b1;
        tick();
        eat_i = 1'b0;
        repeat (7) tick();
        nRst = 1'b0;
        #1;
        tests++;
        if (freq !== 9'd0 || playSound !== 1'b0 || busy !== 1'b0) begin
            fails++;
            $display("FAIL reset_async freq=%0d play=%0b busy=%0b exp 0/0/0", freq, playSound, busy);
        end
        @(negedge clk);
        nRst = 1'b1;
        tick();
        tick();
        tests++;
        if (freq !== 9'd0 || busy !== 1'b0) begin
            fails++;
            $display("FAIL reset_stays_idle freq=%0d busy=%0b exp 0/0", freq, busy);
        end
    endtask

    task automatic test_eat();
        eat_i = 1'b1;
        tick();
        eat_i = 1'b0;
        for (int k = 0; k <= 18; k++) begin
            if (k > 0) tick();
            tests++;
            if (freq !== 9'(exp_freq(0, k, 2)) || busy !== exp_busy(0, k, 2) ||
                playSound !== (exp_freq(0, k, 2) != 0)) begin
                fails++;
                $display("FAIL eat k=%0d freq=%0d busy=%0b play=%0b exp freq=%0d busy=%0b",
                         k, freq, busy, playSound, exp_freq(0, k, 2), exp_busy(0, k, 2));
            end
        end
    endtask

    task automatic test_crash();
        crash_i = 1'b1;
        tick();
        crash_i = 1'b0;
        for (int k = 0; k <= 23; k++) begin
            if (k > 0) tick();
            tests++;
            if (freq !== 9'(exp_freq(1, k, 2)) || busy !== exp_busy(1, k, 2)) begin
                fails++;
                $display("FAIL crash k=%0d freq=%0d busy=%0b exp freq=%0d busy=%0b",
                         k, freq, busy, exp_freq(1, k, 2), exp_busy(1, k, 2));
            end
        end
    endtask

    task automatic test_simultaneous();
        eat_i = 1'b1;
        crash_i = 1'b1;
        tick();
        eat_i = 1'b0;
        crash_i = 1'b0;
        for (int k = 0; k <= 23; k++) begin
            if (k > 0) tick();
            if (k == 7) eat_i = 1'b1;
            if (k == 8) eat_i = 1'b0;
            tests++;
            if (freq !== 9'(exp_freq(1, k, 2)) || busy !== exp_busy(1, k, 2)) begin
                fails++;
                $display("FAIL simultaneous k=%0d freq=%0d busy=%0b exp freq=%0d busy=%0b",
                         k, freq, busy, exp_freq(1, k, 2), exp_busy(1, k, 2));
            end
        end
    endtask

    task automatic test_preempt();
        eat_i = 1'b1;
        tick();
        eat_i = 1'b0;
        repeat (7) tick();
        tests++;
        if (freq !== 9'd330) begin
            fails++;
            $display("FAIL preempt_eat_note1 freq=%0d exp 330", freq);
        end
        crash_i = 1'b1;
        tick();
        crash_i = 1'b0;
        for (int k = 0; k <= 23; k++) begin
            if (k > 0) tick();
            tests++;
            if (freq !== 9'(exp_freq(1, k, 2)) || busy !== exp_busy(1, k, 2)) begin
                fails++;
                $display("FAIL preempt_crash k=%0d freq=%0d busy=%0b exp freq=%0d busy=%0b",
                         k, freq, busy, exp_freq(1, k, 2), exp_busy(1, k, 2));
            end
        end
        // eat held high for 30 cycles: exactly one melody
        eat_i = 1'b1;
        for (int k = 0; k < 30; k++) begin
            tick();
            tests++;
            if (freq !== 9'(exp_freq(0, k, 2)) || busy !== exp_busy(0, k, 2)) begin
                fails++;
                $display("FAIL eat_held k=%0d freq=%0d busy=%0b exp freq=%0d busy=%0b",
                         k, freq, busy, exp_freq(0, k, 2), exp_busy(0, k, 2));
            end
        end
        eat_i = 1'b0;
        tick();
    endtask

    task automatic test_mute();
        eat_i = 1'b1;
        tick();
        eat_i = 1'b0;
        tick();
        tick();
        sound_en = 1'b0;
        tick();
        tests++;
        if (freq !== 9'd0 || playSound !== 1'b0 || busy !== 1'b0) begin
            fails++;
            $display("FAIL mute_abort freq=%0d play=%0b busy=%0b exp 0/0/0", freq, playSound, busy);
        end
        crash_i = 1'b1;
        tick();
        crash_i = 1'b0;
        eat_i = 1'b1;
        tick();
        eat_i = 1'b0;
        sound_en = 1'b1;
        for (int k = 0; k < 4; k++) begin
            tick();
            tests++;
            if (freq !== 9'd0 || busy !== 1'b0) begin
                fails++;
                $display("FAIL mute_events_dropped k=%0d freq=%0d busy=%0b exp 0/0", k, freq, busy);
            end
        end
    endtask

    task automatic test_no_gap();
        eat_i = 1'b1;
        tick();
        eat_i = 1'b0;
        for (int k = 0; k <= 13; k++) begin
            if (k > 0) tick();
            tests++;
            if (freq0 !== 9'(exp_freq(0, k, 0)) || busy0 !== exp_busy(0, k, 0) ||
                playSound0 !== (exp_freq(0, k, 0) != 0)) begin
                fails++;
                $display("FAIL no_gap k=%0d freq=%0d busy=%0b exp freq=%0d busy=%0b",
                         k, freq0, busy0, exp_freq(0, k, 0), exp_busy(0, k, 0));
            end
        end
        repeat (6) tick();
    endtask

    initial begin
        test_reset();
        test_eat();
        test_crash();
        test_simultaneous();
        test_preempt();
        test_mute();
        test_no_gap();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
